// File: rtl/secret_key_recover_pkg.sv
// key_pkg: constants and types shared by the public-key generator and
// the secret-key recovery block.
package key_pkg;

  localparam int unsigned P_PAR     = 227;
  localparam int unsigned Q_PAR     = 225;
  localparam logic [7:0]  NULL_CHAR = 8'h00;

  localparam logic [1:0]  MODE_DEC  = 2'b01;
  localparam logic [1:0]  MODE_ENC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } sk_rec_state_t;

endpackage : key_pkg

// File: rtl/secret_key_recover_if.sv
// Public-key request / secret-key response handshake bundle.
interface secret_key_recover_if;

  logic       pk_valid;
  logic [7:0] Public_key;
  logic       pk_ready;
  logic [7:0] Secret_key;
  logic       S_K_valid;
  logic       sk_ready;
  logic       err_invalid_pubkey;

  // Requester side: issues public keys, consumes responses.
  modport master (
    output pk_valid, Public_key, sk_ready,
    input  pk_ready, Secret_key, S_K_valid, err_invalid_pubkey
  );

  // Recovery block side.
  modport slave (
    input  pk_valid, Public_key, sk_ready,
    output pk_ready, Secret_key, S_K_valid, err_invalid_pubkey
  );

endinterface : secret_key_recover_if

// File: rtl/secret_key_recover_mod_sub.sv
// key_mod_sub: one conditional-subtraction step of the modular reduction.
// done is set when acc is already within 0..p and no subtraction applies.
module key_mod_sub (
  input  logic [9:0] acc,
  input  logic [9:0] p,
  output logic [9:0] acc_next,
  output logic       done
);

  // Subtract p only while acc exceeds it; never underflows.
  always_comb begin
    done     = (acc <= p);
    acc_next = done ? acc : (acc - p);
  end

endmodule : key_mod_sub

// File: rtl/secret_key_recover.sv
// secret_key_recover: recovers Sk = (Pk + (P - Q)) mod P, residues 1..P,
// with one conditional subtraction per cycle.
// Optional cross-check against the generator's key: SK_RECOVER_XCHECK_EN.
module secret_key_recover
  import key_pkg::*;
#(
  parameter int unsigned P_PAR = key_pkg::P_PAR,
  parameter int unsigned Q_PAR = key_pkg::Q_PAR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
`ifdef SK_RECOVER_XCHECK_EN
  input  logic [7:0]           ref_sk,
  output logic                 sk_mismatch,
`endif
  secret_key_recover_if.slave  bus
);

  localparam logic [9:0] P10   = 10'(P_PAR);
  localparam logic [9:0] DIFF10 = 10'(P_PAR - Q_PAR);

  sk_rec_state_t state_q, state_d;
  logic [9:0]    acc_q, acc_d;
  logic          err_q, err_d;
  logic [9:0]    acc_step;
  logic          step_done;
  logic [9:0]    pk_ext;
  logic          enc_mode;

  assign pk_ext   = {2'b00, bus.Public_key};
  assign enc_mode = (mode == MODE_ENC);

  key_mod_sub u_mod_sub (
    .acc      (acc_q),
    .p        (P10),
    .acc_next (acc_step),
    .done     (step_done)
  );

  // State, accumulator and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Next-state, accumulator load/reduce and error qualification.
  // Range errors pass through REDUCE with acc = 0 and the error preset,
  // which gives them the same one-cycle response latency as in-range keys.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (enc_mode && bus.pk_valid) begin
          state_d = REDUCE;
          if (pk_ext == '0 || pk_ext > P10) begin
            acc_d = '0;
            err_d = 1'b1;
          end else begin
            acc_d = pk_ext + DIFF10;
            err_d = 1'b0;
          end
        end
      end
      REDUCE: begin
        if (!enc_mode) begin
          state_d = IDLE;
          acc_d   = '0;
          err_d   = 1'b0;
        end else if (!step_done) begin
          acc_d = acc_step;
        end else begin
          state_d = DONE;
          if (acc_q == P10 || acc_q == '0) err_d = 1'b1;
        end
      end
      DONE: begin
        if (!enc_mode || bus.sk_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Response outputs are decoded from registered state only.
  always_comb begin
    bus.pk_ready           = (state_q == IDLE) && enc_mode;
    bus.S_K_valid          = (state_q == DONE);
    bus.err_invalid_pubkey = (state_q == DONE) && err_q;
    bus.Secret_key         = ((state_q == DONE) && !err_q) ? acc_q[7:0] : NULL_CHAR;
  end

`ifdef SK_RECOVER_XCHECK_EN
  // Mismatch is computed from next-state values so it rises and clears
  // together with S_K_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_mismatch <= 1'b0;
    end else begin
      sk_mismatch <= (state_d == DONE) && !err_d && (acc_d[7:0] != ref_sk);
    end
  end
`endif

endmodule : secret_key_recover

// File: tb/tb_secret_key_recover.sv
// Directed self-checking bench for secret_key_recover (default P=227, Q=225).
module tb_secret_key_recover;
  import key_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
`ifdef SK_RECOVER_XCHECK_EN
  logic [7:0] ref_sk;
  logic       sk_mismatch;
`endif

  int unsigned checks;
  int unsigned errors;

  secret_key_recover_if bus ();

  secret_key_recover dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
`ifdef SK_RECOVER_XCHECK_EN
    .ref_sk      (ref_sk),
    .sk_mismatch (sk_mismatch),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one key, wait lat cycles, check the response, then release it.
  task automatic req(input string tag, input logic [7:0] pk, input int unsigned lat,
                     input logic [7:0] exp_sk, input logic exp_err);
    bus.Public_key = pk;
    bus.pk_valid   = 1'b1;
    chk({tag, "_pk_ready"}, 10'(bus.pk_ready), 10'd1);
    tick();
    bus.pk_valid   = 1'b0;
    bus.Public_key = 8'h00;
    for (int unsigned i = 0; i < lat; i++) begin
      chk({tag, "_early_valid"}, 10'(bus.S_K_valid), 10'd0);
      tick();
    end
    chk({tag, "_valid"}, 10'(bus.S_K_valid), 10'd1);
    chk({tag, "_sk"},    10'(bus.Secret_key), 10'(exp_sk));
    chk({tag, "_err"},   10'(bus.err_invalid_pubkey), 10'(exp_err));
    bus.sk_ready = 1'b1;
    tick();
    bus.sk_ready = 1'b0;
    chk({tag, "_released"}, 10'(bus.S_K_valid), 10'd0);
    chk({tag, "_ready_again"}, 10'(bus.pk_ready), 10'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    mode           = 2'b00;
    bus.pk_valid   = 1'b0;
    bus.Public_key = 8'h00;
    bus.sk_ready   = 1'b0;
`ifdef SK_RECOVER_XCHECK_EN
    ref_sk         = 8'h00;
`endif

    #1;
    chk("rst_valid",    10'(bus.S_K_valid), 10'd0);
    chk("rst_sk",       10'(bus.Secret_key), 10'd0);
    chk("rst_err",      10'(bus.err_invalid_pubkey), 10'd0);
    chk("rst_pk_ready", 10'(bus.pk_ready), 10'd0);
`ifdef SK_RECOVER_XCHECK_EN
    chk("rst_mismatch", 10'(sk_mismatch), 10'd0);
`endif
    #20;
    rst_n = 1'b1;
    tick();
    chk("dec_mode_pk_ready", 10'(bus.pk_ready), 10'd0);
    mode = MODE_ENC;
    #1;

    // Main function: single-step and two-step reductions, residue boundaries.
    req("pk5",   8'd5,   1, 8'd7,   1'b0);
    req("pk1",   8'd1,   1, 8'd3,   1'b0);
    req("pk224", 8'd224, 1, 8'd226, 1'b0);
    req("pk226", 8'd226, 2, 8'd1,   1'b0);
    req("pk227", 8'd227, 2, 8'd2,   1'b0);

    // Error responses: acc == P, zero key, out-of-range keys.
    req("pk225", 8'd225, 1, 8'h00, 1'b1);
    req("pk0",   8'd0,   1, 8'h00, 1'b1);
    req("pk228", 8'd228, 1, 8'h00, 1'b1);
    req("pk255", 8'd255, 1, 8'h00, 1'b1);

    // Held response under backpressure.
    bus.Public_key = 8'd100;
    bus.pk_valid   = 1'b1;
    tick();
    bus.pk_valid   = 1'b0;
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      chk("hold_valid",    10'(bus.S_K_valid), 10'd1);
      chk("hold_sk",       10'(bus.Secret_key), 10'd102);
      chk("hold_pk_ready", 10'(bus.pk_ready), 10'd0);
      tick();
    end
    bus.sk_ready = 1'b1;
    #1;
    chk("hold_pk_ready_same_cycle", 10'(bus.pk_ready), 10'd0);
    tick();
    bus.sk_ready = 1'b0;
    chk("hold_released",   10'(bus.S_K_valid), 10'd0);
    chk("hold_pk_ready_after", 10'(bus.pk_ready), 10'd1);

    // Mode abort while reducing Pk = 226.
    bus.Public_key = 8'd226;
    bus.pk_valid   = 1'b1;
    tick();
    bus.pk_valid   = 1'b0;
    mode           = MODE_DEC;
    tick();
    chk("abort_valid", 10'(bus.S_K_valid), 10'd0);
    chk("abort_sk",    10'(bus.Secret_key), 10'd0);
    chk("abort_err",   10'(bus.err_invalid_pubkey), 10'd0);
    chk("abort_pk_ready", 10'(bus.pk_ready), 10'd0);
    tick();
    chk("abort_no_late_valid", 10'(bus.S_K_valid), 10'd0);
    mode = MODE_ENC;
    #1;
    chk("abort_pk_ready_enc", 10'(bus.pk_ready), 10'd1);

    // Asynchronous reset in the middle of a two-step reduction.
    bus.Public_key = 8'd227;
    bus.pk_valid   = 1'b1;
    tick();
    bus.pk_valid   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 10'(bus.S_K_valid), 10'd0);
    chk("arst_sk",    10'(bus.Secret_key), 10'd0);
    chk("arst_err",   10'(bus.err_invalid_pubkey), 10'd0);
    tick();
    chk("arst_hold_valid", 10'(bus.S_K_valid), 10'd0);
    #2;
    rst_n = 1'b1;
    tick();
    req("post_rst_pk5", 8'd5, 1, 8'd7, 1'b0);

`ifdef SK_RECOVER_XCHECK_EN
    // Cross-check against the generator's key for Pk = 224 (Sk = 226).
    for (int unsigned k = 0; k < 2; k++) begin
      ref_sk = (k == 0) ? 8'd226 : 8'd225;
      bus.Public_key = 8'd224;
      bus.pk_valid   = 1'b1;
      tick();
      bus.pk_valid   = 1'b0;
      tick();
      chk("xchk_valid",    10'(bus.S_K_valid), 10'd1);
      chk("xchk_mismatch", 10'(sk_mismatch), (k == 0) ? 10'd0 : 10'd1);
      bus.sk_ready = 1'b1;
      tick();
      bus.sk_ready = 1'b0;
      chk("xchk_mismatch_clear", 10'(sk_mismatch), 10'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_secret_key_recover
